spi_cmd_decoder: RTL



---
 rtl/spi_cmd_pkg.sv | 37 +++
 rtl/spi_cmd_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command decoder.
package spi_cmd_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_REG     = 8'h89;
    localparam logic [7:0] CMD_FIFO_RD = 8'h8A;
    localparam logic [7:0] CMD_FIFO_WR = 8'h8B;

    // Register address whose write (with data bit 0 set) clears the sticky flags
    localparam logic [6:0] CLR_ADDR = 7'h7F;

    // Frame-parsing states
    typedef enum logic [2:0] {
        StIdle,
        StRegAddr,
        StRegWdata,
        StRegPad,
        StRegRdata,
        StFifoRd,
        StFifoWr
    } state_e;

    // Source of the next tx byte, applied two cycles after the triggering byte
    typedef enum logic [2:0] {
        RspNone,
        RspReg,
        RspFifo,
        RspIdle,
        RspEmpty
    } rsp_sel_e;

    // True for a register write that clears the sticky error flags
    function automatic logic is_clear_write(input logic [6:0] addr, input logic [7:0] data);
        return (addr == CLR_ADDR) && data[0];
    endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// Byte-level command decoder: parses framed host commands from the SPI slave,
// issues single-cycle register/FIFO strobes and loads the response byte.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE  = 8'h00,
    parameter logic [7:0] EMPTY_BYTE = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ss_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic [7:0] tx_data_o,
    output logic [6:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic [7:0] wf_data_o,
    output logic       wf_push_o,
    input  logic       wf_full_i,
    output logic       rf_pop_o,
    input  logic [7:0] rf_data_i,
    input  logic       rf_empty_i,
    output logic       ovf_o,
    output logic       udf_o
);

    state_e     state_q, state_d;
    rsp_sel_e   rsp1_q, rsp1_d;
    rsp_sel_e   rsp2_q, rsp2_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] wf_data_q, wf_data_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       push_q, push_d;
    logic       pop_q, pop_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, strobe and response-pipeline registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp1_q    <= RspNone;
            rsp2_q    <= RspNone;
            tx_q      <= IDLE_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wf_data_q <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            rsp1_q    <= rsp1_d;
            rsp2_q    <= rsp2_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wf_data_q <= wf_data_d;
            we_q      <= we_d;
            re_q      <= re_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Frame parser: next state, strobes, latched fields, flags, response select
    always_comb begin
        state_d   = state_q;
        rsp1_d    = RspNone;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wf_data_d = wf_data_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (ss_i) begin
            // Deselect abandons any partial frame; bytes seen now are ignored
            state_d = StIdle;
        end else if (rx_valid_i) begin
            case (state_q)
                StIdle: begin
                    if (rx_data_i == CMD_REG) begin
                        state_d = StRegAddr;
                    end else if (rx_data_i == CMD_FIFO_RD) begin
                        state_d = StFifoRd;
                        if (rf_empty_i) begin
                            udf_d  = 1'b1;
                            rsp1_d = RspEmpty;
                        end else begin
                            pop_d  = 1'b1;
                            rsp1_d = RspFifo;
                        end
                    end else if (rx_data_i == CMD_FIFO_WR) begin
                        state_d = StFifoWr;
                    end
                end
                StRegAddr: begin
                    addr_d = rx_data_i[6:0];
                    if (rx_data_i[7]) begin
                        state_d = StRegWdata;
                    end else begin
                        re_d    = 1'b1;
                        rsp1_d  = RspReg;
                        state_d = StRegRdata;
                    end
                end
                StRegWdata: begin
                    wdata_d = rx_data_i;
                    we_d    = 1'b1;
                    if (is_clear_write(addr_q, rx_data_i)) begin
                        ovf_d = 1'b0;
                        udf_d = 1'b0;
                    end
                    state_d = StRegPad;
                end
                StRegPad, StRegRdata, StFifoRd: begin
                    rsp1_d  = RspIdle;
                    state_d = StIdle;
                end
                StFifoWr: begin
                    if (wf_full_i) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_d    = 1'b1;
                        wf_data_d = rx_data_i;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Response loader: select is delayed one cycle so read data has arrived
    always_comb begin
        rsp2_d = ss_i ? RspNone : rsp1_q;
        tx_d   = tx_q;
        case (rsp2_q)
            RspReg:   tx_d = reg_rdata_i;
            RspFifo:  tx_d = rf_data_i;
            RspIdle:  tx_d = IDLE_BYTE;
            RspEmpty: tx_d = EMPTY_BYTE;
            default:  tx_d = tx_q;
        endcase
        // Deselect drops any in-flight response
        if (ss_i) begin
            tx_d = IDLE_BYTE;
        end
    end

    assign tx_data_o   = tx_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign wf_data_o   = wf_data_q;
    assign wf_push_o   = push_q;
    assign rf_pop_o    = pop_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;

endmodule
